// File: rtl/fifo_stream_reader.sv
// Drains the video FIFO head into a one-entry AXI4-Stream register, tagging start-of-frame and end-of-line from latched frame dimensions.
// One cycle from fifo_rd to m_tvalid; while m_tvalid & ~m_tready the register holds and no pop is issued.
module fifo_stream_reader #(
    parameter int W  = 10,
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          enable,
    input  logic [CW-1:0] h_size,
    input  logic [CW-1:0] v_size,
    output logic          fifo_rd,
    input  logic [W-1:0]  fifo_rddata,
    input  logic          fifo_empty,
    output logic          m_tvalid,
    input  logic          m_tready,
    output logic [W-1:0]  m_tdata,
    output logic          m_tuser,
    output logic          m_tlast,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_FLUSH  = 2'd2
    } state_t;

    localparam logic [CW-1:0] ONE = CW'(1);

    state_t        state_q, state_d;
    logic [CW-1:0] h_lat_q, h_lat_d;
    logic [CW-1:0] v_lat_q, v_lat_d;
    logic [CW-1:0] x_cnt_q, x_cnt_d;
    logic [CW-1:0] y_cnt_q, y_cnt_d;
    logic          tvalid_q, tvalid_d;
    logic [W-1:0]  tdata_q, tdata_d;
    logic          tuser_q, tuser_d;
    logic          tlast_q, tlast_d;
    logic          done_q, done_d;

    logic start;
    logic load;
    logic hs;
    logic x_end;
    logic y_end;
    logic last_beat;

    // Sizes are checked live only at frame start; inside a frame only the latched copies matter.
    assign hs        = tvalid_q & m_tready;
    assign start     = (state_q == S_IDLE) & enable & (h_size != '0) & (v_size != '0);
    assign load      = (state_q == S_ACTIVE) & ~fifo_empty & (~tvalid_q | m_tready);
    assign x_end     = (x_cnt_q == h_lat_q - ONE);
    assign y_end     = (y_cnt_q == v_lat_q - ONE);
    assign last_beat = load & x_end & y_end;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            h_lat_q  <= '0;
            v_lat_q  <= '0;
            x_cnt_q  <= '0;
            y_cnt_q  <= '0;
            tvalid_q <= 1'b0;
            tdata_q  <= '0;
            tuser_q  <= 1'b0;
            tlast_q  <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            h_lat_q  <= h_lat_d;
            v_lat_q  <= v_lat_d;
            x_cnt_q  <= x_cnt_d;
            y_cnt_q  <= y_cnt_d;
            tvalid_q <= tvalid_d;
            tdata_q  <= tdata_d;
            tuser_q  <= tuser_d;
            tlast_q  <= tlast_d;
            done_q   <= done_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        unique case (state_q)
            S_IDLE:   if (start)     state_d = S_ACTIVE;
            S_ACTIVE: if (last_beat) state_d = S_FLUSH;
            S_FLUSH:  if (hs)        state_d = S_IDLE;
            default:                 state_d = S_IDLE;
        endcase
    end

    always_comb begin : datapath
        h_lat_d  = h_lat_q;
        v_lat_d  = v_lat_q;
        x_cnt_d  = x_cnt_q;
        y_cnt_d  = y_cnt_q;
        tvalid_d = tvalid_q;
        tdata_d  = tdata_q;
        tuser_d  = tuser_q;
        tlast_d  = tlast_q;
        done_d   = (state_q == S_FLUSH) & hs;

        if (start) begin
            h_lat_d = h_size;
            v_lat_d = v_size;
            x_cnt_d = '0;
            y_cnt_d = '0;
        end

        // A load may coincide with the handshake of the previous beat: the register is simply overwritten.
        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = fifo_rddata;
            tuser_d  = (x_cnt_q == '0) & (y_cnt_q == '0);
            tlast_d  = x_end;
            if (x_end) begin
                x_cnt_d = '0;
                y_cnt_d = y_end ? '0 : y_cnt_q + ONE;
            end else begin
                x_cnt_d = x_cnt_q + ONE;
            end
        end else if (hs) begin
            tvalid_d = 1'b0;
        end
    end

    always_comb begin : outputs
        fifo_rd    = load;
        busy       = (state_q != S_IDLE);
        m_tvalid   = tvalid_q;
        m_tdata    = tdata_q;
        m_tuser    = tuser_q;
        m_tlast    = tlast_q;
        frame_done = done_q;
    end

endmodule

// File: doc/fifo_stream_reader.md
# fifo_stream_reader

Read-side drain for the video-path shift-register FIFO. It pops words from the FIFO head whenever its one-entry output register is free and presents them as an AXI4-Stream master with frame and line sideband. It counts pixels and lines against runtime frame dimensions, marks start-of-frame (tuser) and end-of-line (tlast), and stops cleanly at frame boundaries when disabled. It sits between the FIFO and the downstream stream consumer, such as the DMA write or the feature pipeline.

## Interface
- W, 10: data width; matches the FIFO word width.
- CW, 12: width of the h_size / v_size fields and the internal counters.
- clk  input  1  clock; all logic on posedge.
- rst_n  input  1  asynchronous, active-low reset.
- enable  input  1  level; permits frame start; sampled only in IDLE.
- h_size  input  CW  pixels per line; latched at frame start.
- v_size  input  CW  lines per frame; latched at frame start.
- fifo_rd  output  1  pop strobe to FIFO; combinational.
- fifo_rddata  input  W  FIFO head word; valid whenever fifo_empty=0.
- fifo_empty  input  1  FIFO empty flag.
- m_tvalid  output  1  stream valid.
- m_tready  input  1  stream ready.
- m_tdata  output  W  stream data.
- m_tuser  output  1  start of frame; 1 on the first beat of a frame (x=0, y=0).
- m_tlast  output  1  end of line; 1 on the beat with x=h_size-1.
- busy  output  1  1 while the state is not IDLE.
- frame_done  output  1  one-cycle pulse on handshake of the frame's final beat.

## Operation
- States:
  - IDLE: no pops.
  - ACTIVE: pops allowed.
  - FLUSH: all beats of the frame are loaded; waiting for the last output handshake.
- IDLE->ACTIVE: enable=1, h_size!=0, v_size!=0. Latch h_size and v_size, clear x_cnt and y_cnt. Zero dimensions hold the block in IDLE.
- Load condition in ACTIVE:
  - load = ~fifo_empty & (~m_tvalid | m_tready).
  - fifo_rd = load, asserted only in ACTIVE.
  - fifo_rd is never asserted while fifo_empty=1.
  - fifo_rd is never asserted simultaneously with FIFO wr by this block; the FIFO handles wr&rd itself.
- On load:
  - m_tdata <= fifo_rddata; m_tvalid <= 1.
  - m_tuser <= (x_cnt==0 & y_cnt==0); m_tlast <= (x_cnt==h_lat-1).
  - Advance x_cnt. On wrap, x_cnt <= 0 and y_cnt <= y_cnt+1.
- Last beat of the frame loaded (x=h_lat-1, y=v_lat-1): ACTIVE->FLUSH; counters clear to 0.
- No load while m_tvalid & ~m_tready: handshake on m_tvalid & m_tready clears m_tvalid.
- FLUSH: handshake of the final beat -> frame_done=1 for one cycle -> IDLE.
- A new frame requires passing through IDLE, so enable is re-checked every frame.
- Deasserting enable mid-frame has no effect; the frame completes.
- Counter arithmetic is CW-bit unsigned. Comparisons use the latched sizes. Changes to h_size/v_size mid-frame are ignored.
- FIFO underrun mid-frame stalls the stream (m_tvalid drops after the drain); there is no timeout.
- Reset mid-frame: all state clears immediately. Words already in the FIFO are not discarded by this block.

## Timing
- Reset values: m_tvalid=0, m_tdata=0, m_tuser=0, m_tlast=0, busy=0, frame_done=0, fifo_rd=0, state=IDLE, counters=0.
- Frame start: enable high in IDLE -> busy=1 on the next cycle; the first fifo_rd is possible in that same cycle (ACTIVE).
- Latency: a word at the FIFO head with fifo_rd=1 in cycle N appears on m_tdata with m_tvalid=1 in cycle N+1.
- Throughput: 1 word/cycle with m_tready held 1 and the FIFO non-empty.
- Backpressure: m_tdata, m_tuser and m_tlast stay stable while m_tvalid & ~m_tready. fifo_rd=0 during that time.
- Simultaneous handshake and load in the same cycle: the output register is replaced with the new word, with no bubble.
- frame_done is asserted in the cycle after the final handshake, coinciding with the return of busy... busy=0 from the following cycle.
- Frame-to-frame gap: at least 2 cycles with no pop (FLUSH exit, then IDLE).

## Test plan
- Basic frame: h_size=4, v_size=2, FIFO pre-filled with 8 words 0x001..0x008, m_tready=1 -> 8 consecutive beats. tuser on 0x001 only; tlast on 0x004 and 0x008. frame_done pulses one cycle after the 0x008 handshake; busy=0 after.
- Backpressure: same frame, m_tready toggles 1,0,0,1 repeatedly -> no lost or duplicated words; data and sideband stable during stalls; fifo_rd never asserted with fifo_empty=1.
- Underrun: FIFO supplies 3 words, pauses 10 cycles, then supplies the remaining 5 -> m_tvalid drops during the gap, the sequence stays intact, tlast still lands on the 4th and 8th beats.
- Enable drop mid-frame: enable=0 after beat 3 of a 4x2 frame -> all 8 beats are output, frame_done pulses, the block stays in IDLE with further FIFO data untouched.
- Zero size and latch: v_size=0 with enable=1 -> busy stays 0. Then h_size=3, v_size=1, with h_size changed to 7 after start -> tlast on the 3rd beat.
- Async reset mid-frame: rst_n low for 2 cycles after beat 2 -> all outputs 0 immediately. After release with enable=1, the next beat carries tuser=1.
